// File: rtl/afifo_pkg.sv
// Shared types and sizing helpers for the async FIFO read-side adapter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package afifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int BUF_DEPTH_MIN  = 3;

  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/afifo_rd_skid_buf.sv
// Circular skid buffer holding words already read out of the async FIFO.
// Latency: push visible at dout one clk later when empty; dout is registered state.
// Backpressure: none internally; the caller's credit rule guarantees no overflow.
module afifo_rd_skid_buf
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3,
  parameter int CW         = cnt_width(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]         count
);
  localparam int              AW   = $clog2(BUF_DEPTH);
  localparam logic [AW-1:0]   LAST = AW'(BUF_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  // Pointers wrap explicitly because the depth need not be a power of two.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy update; clear wins over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are don't-care after clear, so no reset.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/afifo_rd_stream_adapter.sv
// Async FIFO read-side consumer presenting a valid/ready stream (optional stats: AFIFO_RD_STATS_EN).
// Latency: rinc at cycle N -> m_valid at N+2; sustains 1 word/clk.
// Backpressure: credit-based read (buffered + in-flight < BUF_DEPTH); rinc never depends on m_ready.
module afifo_rd_stream_adapter
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef AFIFO_RD_STATS_EN
  ,
  output logic [31:0]           beat_cnt,
  output logic [31:0]           stall_cnt
`endif
);
  localparam int            CW      = cnt_width(BUF_DEPTH);
  localparam logic [CW:0]   DEPTH_L = (CW + 1)'(BUF_DEPTH);

  if (BUF_DEPTH < BUF_DEPTH_MIN) begin : g_depth_chk
    $fatal(1, "afifo_rd_stream_adapter: BUF_DEPTH must be >= 3 to cover rdata latency");
  end

  logic          rd_q;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          clr;
  logic          push;
  logic          pop;

  // A word in flight already owns a buffer slot, so it counts against credit.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, rd_q};
  assign rinc        = !rrst && !flush && !rempty && (credit_used < DEPTH_L);

  assign clr     = rrst || flush;
  assign push    = rd_q && !clr;
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready && !clr;

  // Track the word requested last cycle; it lands on rdata this cycle.
  always_ff @(posedge rclk) begin
    if (clr) rd_q <= 1'b0;
    else     rd_q <= rinc;
  end

  afifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH),
    .CW         (CW)
  ) u_skid (
    .clk   (rclk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (rdata),
    .dout  (m_data),
    .count (count)
  );

`ifdef AFIFO_RD_STATS_EN
  // Beat and stall counters, free-running with natural 32-bit wrap.
  always_ff @(posedge rclk) begin
    if (clr) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop)                 beat_cnt  <= beat_cnt + 32'd1;
      if (m_valid && !m_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_afifo_rd_stream_adapter.sv
// Directed self-checking bench for afifo_rd_stream_adapter with a behavioural FIFO read port.
// Latency: FIFO model returns rdata one rclk after rinc; rempty is registered.
// Backpressure: m_ready driven directly by the stimulus sequence.
module tb_afifo_rd_stream_adapter;
  logic       rclk = 1'b0;
  logic       rrst;
  logic       rempty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       rinc;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef AFIFO_RD_STATS_EN
  logic [31:0] beat_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int rinc_cnt = 0;
  int beat_n = 0;
  int bad_rd = 0;
  logic [7:0] last_beat = 8'h00;
  logic [7:0] fq [$];

  afifo_rd_stream_adapter #(.DATA_WIDTH(8), .BUF_DEPTH(3)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef AFIFO_RD_STATS_EN
    ,
    .beat_cnt  (beat_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  // FIFO read port model: registered rdata and rempty; its own reset clears it.
  always @(posedge rclk) begin
    if (rrst) begin
      fq.delete();
      rempty <= 1'b1;
    end else begin
      if (rinc) begin
        if (rempty || fq.size() == 0) bad_rd <= bad_rd + 1;
        else rdata <= fq.pop_front();
      end
      rempty <= (fq.size() == 0);
    end
  end

  // Read-strobe and accepted-beat monitor.
  always @(posedge rclk) begin
    if (!rrst && rinc) rinc_cnt <= rinc_cnt + 1;
    if (!rrst && !flush && m_valid && m_ready) begin
      beat_n    <= beat_n + 1;
      last_beat <= m_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge rclk);
  endtask

  initial begin
    int r0;
    int b0;
    bit got;
    rrst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    ticks(2);
    chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
    chk("reset_rinc",    {31'd0, rinc},    32'd0);

    // 1: four words streamed with m_ready high
    rrst = 1'b0; m_ready = 1'b1;
    r0 = rinc_cnt;
    for (int i = 0; i < 4; i++) fq.push_back(8'hA0 + 8'(i));
    ticks(1);
    chk("t1_first_rinc", {31'd0, rinc},    32'd1);
    chk("t1_valid_n",    {31'd0, m_valid}, 32'd0);
    ticks(1);
    chk("t1_valid_n1",   {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      ticks(1);
      chk("t1_valid", {31'd0, m_valid}, 32'd1);
      chk("t1_data",  {24'd0, m_data},  32'hA0 + i);
    end
    ticks(1);
    chk("t1_drained",  {31'd0, m_valid}, 32'd0);
    chk("t1_rinc_cnt", rinc_cnt - r0,    32'd4);

    // 2: backpressure with 10 words waiting
    m_ready = 1'b0;
    r0 = rinc_cnt;
    for (int i = 0; i < 10; i++) fq.push_back(8'hB0 + 8'(i));
    ticks(8);
    chk("t2_rinc_pulses", rinc_cnt - r0,    32'd3);
    chk("t2_rinc_idle",   {31'd0, rinc},    32'd0);
    chk("t2_valid",       {31'd0, m_valid}, 32'd1);
    chk("t2_head",        {24'd0, m_data},  32'hB0);
    ticks(2);
    chk("t2_head_stable", {24'd0, m_data},  32'hB0);
    m_ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      ticks(1);
      chk("t2_stream_valid", {31'd0, m_valid}, 32'd1);
      chk("t2_stream_data",  {24'd0, m_data},  32'hB0 + i);
    end
    ticks(1);
    chk("t2_drained", {31'd0, m_valid}, 32'd0);

    // 3: empty FIFO, m_ready toggling, then a single word
    r0 = rinc_cnt; b0 = beat_n;
    for (int i = 0; i < 6; i++) begin
      m_ready = i[0];
      ticks(1);
      chk("t3_rinc_empty",  {31'd0, rinc},    32'd0);
      chk("t3_valid_empty", {31'd0, m_valid}, 32'd0);
    end
    m_ready = 1'b1;
    fq.push_back(8'hC5);
    ticks(6);
    chk("t3_one_rinc", rinc_cnt - r0,    32'd1);
    chk("t3_one_beat", beat_n - b0,      32'd1);
    chk("t3_beat_val", {24'd0, last_beat}, 32'hC5);

    // 4: flush with two buffered words and one in flight
    m_ready = 1'b0;
    fq.push_back(8'hD0); fq.push_back(8'hD1); fq.push_back(8'hD2); fq.push_back(8'hE0);
    ticks(4);
    chk("t4_pre_valid", {31'd0, m_valid}, 32'd1);
    chk("t4_pre_head",  {24'd0, m_data},  32'hD0);
    chk("t4_pre_rinc",  {31'd0, rinc},    32'd0);
    flush = 1'b1; m_ready = 1'b1;
    #1;
    chk("t4_flush_rinc", {31'd0, rinc}, 32'd0);
    b0 = beat_n;
    ticks(1);
    flush = 1'b0;
    chk("t4_post_valid", {31'd0, m_valid}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      ticks(1);
      if (m_valid) got = 1'b1;
    end
    chk("t4_got_word",  {31'd0, got},    32'd1);
    chk("t4_next_word", {24'd0, m_data}, 32'hE0);
    ticks(1);
    chk("t4_end_valid", {31'd0, m_valid}, 32'd0);
    chk("t4_beats",     beat_n - b0,      32'd1);

    // 5: reset pulse mid-burst
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) fq.push_back(8'hF0 + 8'(i));
    ticks(3);
    chk("t5_burst_valid", {31'd0, m_valid}, 32'd1);
    chk("t5_burst_rinc",  {31'd0, rinc},    32'd1);
    rrst = 1'b1;
    #1;
    chk("t5_rst_rinc", {31'd0, rinc}, 32'd0);
    ticks(1);
    chk("t5_rst_valid",  {31'd0, m_valid}, 32'd0);
    chk("t5_rst_rinc2",  {31'd0, rinc},    32'd0);
    rrst = 1'b0;
    ticks(2);
    chk("t5_idle_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_idle_rinc",  {31'd0, rinc},    32'd0);

`ifdef AFIFO_RD_STATS_EN
    // 6: stats counters, 3 stall cycles then 5 beats, then flush
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fq.push_back(8'h60 + 8'(i));
    ticks(3);
    chk("t6_valid", {31'd0, m_valid}, 32'd1);
    ticks(3);
    m_ready = 1'b1;
    ticks(5);
    chk("t6_drained",  {31'd0, m_valid}, 32'd0);
    chk("t6_beat_cnt",  beat_cnt,  32'd5);
    chk("t6_stall_cnt", stall_cnt, 32'd3);
    flush = 1'b1;
    ticks(1);
    flush = 1'b0;
    chk("t6_beat_clr",  beat_cnt,  32'd0);
    chk("t6_stall_clr", stall_cnt, 32'd0);
`endif

    chk("no_read_when_empty", bad_rd, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
